spi_adc_master: RTL

- SPI master that reads a 16-bit frame from the serial ADC (the `spi_slave_adc` side of the link).
- Each frame is 4 leading zeros followed by 12 data bits, MSB first. The master drives `sclk`/`cs_n`, samples `sdata`, and presents the 12-bit result with a one-cycle valid strobe.
- Sits inside `top`, directly upstream of the temperature/control logic that drives LED, heat, motor, FND and UART.
- Supports single-shot (button) and continuous conversion.

---
 rtl/spi_adc_master.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spi_adc_master.sv
// SPI master for the serial ADC: reads a 16-bit frame (4 zero bits + 12 data bits, MSB first).
// Optional build macro ADC_AVG4_EN averages four frames per data_valid strobe.
module spi_adc_master #(
  parameter int HALF_DIV   = 50,
  parameter int CS_SETUP   = 2,
  parameter int QUIET_CLKS = 50,
  parameter int IDLE_CLKS  = 1000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        cont_en,
  input  logic        sdata,
  output logic        sclk,
  output logic        cs_n,
  output logic [11:0] adc_data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] QUIET = 3'd4;

  localparam int MAXC   = (HALF_DIV > CS_SETUP) ?
                          ((HALF_DIV > QUIET_CLKS) ? HALF_DIV : QUIET_CLKS) :
                          ((CS_SETUP > QUIET_CLKS) ? CS_SETUP : QUIET_CLKS);
  localparam int CNT_W  = $clog2(MAXC + 1);
  localparam int IDLE_W = (IDLE_CLKS > 1) ? $clog2(IDLE_CLKS) : 1;

  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0]  QUIET_LAST = CNT_W'(QUIET_CLKS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_CLKS - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [5:0]        edges;   // sclk edges issued this frame, 1..32
  logic [15:0]       shreg;

`ifdef ADC_AVG4_EN
  logic [13:0] sum;
  logic [1:0]  fcnt;
  logic        err_acc;
  logic [13:0] sum_nxt;
  logic        err_nxt;
  assign sum_nxt = sum + {2'b00, shreg[11:0]};
  assign err_nxt = err_acc | (|shreg[15:12]);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idle_cnt   <= '0;
      edges      <= '0;
      shreg      <= '0;
      sclk       <= 1'b1;
      cs_n       <= 1'b1;
      adc_data   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef ADC_AVG4_EN
      sum        <= '0;
      fcnt       <= '0;
      err_acc    <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start || (cont_en && idle_cnt == IDLE_LAST)) begin
            state    <= SETUP;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            idle_cnt <= '0;
          end else if (cont_en) begin
            idle_cnt <= idle_cnt + 1'b1;
          end else begin
            idle_cnt <= '0;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= SHIFT;
            sclk  <= 1'b0;
            edges <= 6'd1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // After the 32nd edge sclk sits high one more half period before HOLD.
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (edges == 6'd32) begin
              state <= HOLD;
            end else begin
              sclk  <= ~sclk;
              edges <= edges + 1'b1;
              if (!sclk) shreg <= {shreg[14:0], sdata};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            cs_n  <= 1'b1;
            state <= QUIET;
`ifdef ADC_AVG4_EN
            if (fcnt == 2'd3) begin
              adc_data   <= sum_nxt[13:2];
              frame_err  <= err_nxt;
              data_valid <= 1'b1;
              sum        <= '0;
              err_acc    <= 1'b0;
            end else begin
              sum     <= sum_nxt;
              err_acc <= err_nxt;
            end
            fcnt <= fcnt + 1'b1;
`else
            adc_data   <= shreg[11:0];
            frame_err  <= |shreg[15:12];
            data_valid <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        QUIET: begin
          if (cnt == QUIET_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
